// File: rtl/i2c_codec_target.sv
// I2C write-only codec target: receives {reg_addr[6:0], data[8:0]} words over
// a 3-byte I2C write and mirrors the low 16 registers in a readable shadow.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk_i2c,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_valid_o,
  output logic [6:0] wr_addr_o,
  output logic [8:0] wr_data_o,
  output logic       busy_o,
  input  logic [3:0] rd_addr_i,
  output logic [8:0] rd_data_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_IGNORE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_scl_sync, r_sda_sync;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_shift, r_byte1;
  logic        r_wr_valid;
  logic [6:0]  r_wr_addr;
  logic [8:0]  r_wr_data;
  logic [8:0]  r_shadow [16];

  logic w_scl, w_scl_d, w_scl_rise, w_scl_fall;
  logic w_start, w_stop, w_byte_done, w_commit, w_bit_clr, w_rx_state;

  // [1] is the synchronized level, [2] its one-cycle delayed copy for edges
  always_ff @(posedge clk_i2c or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], scl_i};
      r_sda_sync <= {r_sda_sync[1:0], sda_i};
    end
  end

  assign w_scl       = r_scl_sync[1];
  assign w_scl_d     = r_scl_sync[2];
  assign w_scl_rise  = w_scl & ~w_scl_d;
  assign w_scl_fall  = ~w_scl & w_scl_d;
  assign w_start     = w_scl & w_scl_d & r_sda_sync[2] & ~r_sda_sync[1];
  assign w_stop      = w_scl & w_scl_d & ~r_sda_sync[2] & r_sda_sync[1];
  assign w_byte_done = w_scl_fall && (r_bitcnt == 4'd8);
  assign w_rx_state  = (r_state == S_DEV) || (r_state == S_BYTE1) || (r_state == S_BYTE2);

  always_ff @(posedge clk_i2c or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    if (!en_i) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_DEV;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_DEV:     if (w_byte_done)
                     w_state_nxt = (r_shift == {DEV_ADDR, 1'b0}) ? S_ACK_DEV : S_IGNORE;
        S_ACK_DEV: if (w_scl_fall) w_state_nxt = S_BYTE1;
        S_BYTE1:   if (w_byte_done) w_state_nxt = S_ACK1;
        S_ACK1:    if (w_scl_fall) w_state_nxt = S_BYTE2;
        S_BYTE2:   if (w_byte_done) begin
                     w_state_nxt = S_ACK2;
                     w_commit    = 1'b1;
                   end
        S_ACK2:    if (w_scl_fall) w_state_nxt = S_IGNORE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Any state change (or a repeated START within DEV) restarts bit counting
  assign w_bit_clr = w_start || (w_state_nxt != r_state);

  always_ff @(posedge clk_i2c or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_byte1    <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      if (w_bit_clr)
        r_bitcnt <= '0;
      else if (w_scl_rise && w_rx_state && (r_bitcnt < 4'd8))
        r_bitcnt <= r_bitcnt + 4'd1;
      if (w_scl_rise && w_rx_state)
        r_shift <= {r_shift[6:0], r_sda_sync[1]};
      if ((r_state == S_BYTE1) && (w_state_nxt == S_ACK1))
        r_byte1 <= r_shift;
      r_wr_valid <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_byte1[7:1];
        r_wr_data <= {r_byte1[0], r_shift};
      end
    end
  end

  always_ff @(posedge clk_i2c or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 16; i++) r_shadow[i] <= '0;
    end else if (r_wr_valid) begin
      if (r_wr_addr == 7'h0F) begin
        for (int unsigned i = 0; i < 16; i++) r_shadow[i] <= '0;
      end else if (r_wr_addr < 7'd16) begin
        r_shadow[r_wr_addr[3:0]] <= r_wr_data;
      end
    end
  end

  assign sda_oe_o   = (r_state == S_ACK_DEV) || (r_state == S_ACK1) || (r_state == S_ACK2);
  assign busy_o     = (r_state != S_IDLE);
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign rd_data_o  = r_shadow[rd_addr_i];

endmodule

// File: tb/tb_i2c_codec_target.sv
// Scoreboard bench for i2c_codec_target: bit-banged I2C master, transaction-level
// model of ACKs/commits/shadow, monitor checking each wr_valid_o pulse.
module tb_i2c_codec_target;

  localparam int H = 12;
  localparam int Q = H / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic [3:0] rd_addr = '0;
  logic [8:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_exp [$];
  logic [8:0]  m_shadow [16];
  logic [7:0]  tx [4];
  logic        prev_valid = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_codec_target #(.DEV_ADDR(7'h1A)) dut (
    .clk_i2c   (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_oe_o  (sda_oe),
    .wr_valid_o(wr_valid),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .busy_o    (busy),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expected write
  always @(negedge clk) begin
    if (wr_valid) begin
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got addr %h data %h expected no pulse", wr_addr, wr_data);
      end else begin
        logic [15:0] e;
        e = q_exp.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write_word: got %h expected %h", {wr_addr, wr_data}, e);
        end
      end
      if (prev_valid) begin
        errors++;
        $display("FAIL pulse_width: got wr_valid high 2 cycles expected 1");
      end
    end
    if (sda_oe && !busy) begin
      errors++;
      $display("FAIL oe_idle: got sda_oe 1 expected 0 while idle");
    end
    prev_valid <= wr_valid;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(H);
    sda_m = 1'b0; wclk(H);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(H);
    sda_m = 1'b1; wclk(H);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wclk(Q);
    scl_m = 1'b1; wclk(H);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(H / 2);
    ack = ~sda_line;
    wclk(H - H / 2);
    scl_m = 1'b0; wclk(Q);
    chk(nm, {15'd0, ack}, {15'd0, exp_ack});
  endtask

  // Transaction-level expectation: only a DEV_ADDR write gets ACKs, on exactly
  // the address byte and two data bytes; the word commits once byte 2 is complete.
  task automatic model_commit(input logic [7:0] b1, input logic [7:0] b2);
    logic [6:0] a;
    logic [8:0] d;
    a = b1[7:1];
    d = {b1[0], b2};
    q_exp.push_back({a, d});
    if (a == 7'h0F) begin
      for (int i = 0; i < 16; i++) m_shadow[i] = '0;
    end else if (a < 7'd16) begin
      m_shadow[a[3:0]] = d;
    end
  endtask

  task automatic xfer(input int n, input logic do_stop);
    logic matched;
    logic exp_ack;
    matched = 1'b0;
    bus_start();
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        matched = (tx[0] == 8'h34);
        exp_ack = matched;
      end else begin
        exp_ack = matched && (i <= 2);
      end
      if (i == 2 && matched) model_commit(tx[1], tx[2]);
      send_byte(tx[i], exp_ack, $sformatf("ack_byte%0d", i));
    end
    if (do_stop) bus_stop();
  endtask

  task automatic check_shadow(input string nm);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
      #1;
      chk($sformatf("%s_rd%0d", nm, i), {7'd0, rd_data}, {7'd0, m_shadow[i]});
    end
  endtask

  task automatic set_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    tx[0] = a; tx[1] = b; tx[2] = c; tx[3] = d;
  endtask

  // Start a write, deliver byte1, then 3 bits of byte2 and abort via reset or enable
  task automatic abort_byte2(input logic use_reset, input logic [7:0] b1);
    bus_start();
    send_byte(8'h34, 1'b1, "abort_ack_dev");
    send_byte(b1, 1'b1, "abort_ack1");
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    if (use_reset) begin
      rst_n = 1'b0;
      for (int i = 0; i < 16; i++) m_shadow[i] = '0;
      #1;
      chk("rst_abort_oe", {15'd0, sda_oe}, 16'd0);
      chk("rst_abort_busy", {15'd0, busy}, 16'd0);
      chk("rst_abort_valid", {15'd0, wr_valid}, 16'd0);
      wclk(3);
      rst_n = 1'b1;
    end else begin
      en = 1'b0;
      wclk(2);
      @(negedge clk);
      chk("en_abort_oe", {15'd0, sda_oe}, 16'd0);
      chk("en_abort_busy", {15'd0, busy}, 16'd0);
      en = 1'b1;
    end
    bus_stop();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_shadow[i] = '0;
    wclk(3);
    @(negedge clk);
    chk("rst_oe", {15'd0, sda_oe}, 16'd0);
    chk("rst_valid", {15'd0, wr_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_addr", {9'd0, wr_addr}, 16'd0);
    chk("rst_data", {7'd0, wr_data}, 16'd0);
    rst_n = 1'b1;
    wclk(5);
    check_shadow("rst");

    set_tx(8'h34, 8'h0C, 8'h10, 8'h00); xfer(3, 1'b1);
    chk("w1_addr", {9'd0, wr_addr}, 16'h0006);
    chk("w1_data", {7'd0, wr_data}, 16'h0010);
    check_shadow("w1");

    set_tx(8'h36, 8'h0C, 8'h10, 8'h00); xfer(3, 1'b1);
    set_tx(8'h35, 8'h0C, 8'h10, 8'h00); xfer(2, 1'b1);
    chk("nack_busy", {15'd0, busy}, 16'd0);

    set_tx(8'h34, 8'h05, 8'h79, 8'h00); xfer(3, 1'b1);
    check_shadow("r2");
    set_tx(8'h34, 8'h1E, 8'h00, 8'h00); xfer(3, 1'b1);
    chk("clr_addr", {9'd0, wr_addr}, 16'h000F);
    check_shadow("clr");

    set_tx(8'h34, 8'h0E, 8'h00, 8'h00); xfer(2, 1'b0);
    set_tx(8'h34, 8'h12, 8'h01, 8'h00); xfer(3, 1'b1);
    chk("rs_addr", {9'd0, wr_addr}, 16'h0009);
    chk("rs_data", {7'd0, wr_data}, 16'h0001);

    set_tx(8'h34, 8'h00, 8'h17, 8'hAA); xfer(4, 1'b1);
    check_shadow("b4");

    set_tx(8'h34, 8'h40, 8'h5A, 8'h00); xfer(3, 1'b1);
    check_shadow("hi_addr");

    abort_byte2(1'b0, 8'h08);
    check_shadow("en_abort");
    abort_byte2(1'b1, 8'h0A);
    check_shadow("rst_abort");
    set_tx(8'h34, 8'h0A, 8'h33, 8'h00); xfer(3, 1'b1);
    check_shadow("post_abort");

    // Enable dropped while the target is driving ACK1
    bus_start();
    send_byte(8'h34, 1'b1, "ack1en_dev");
    for (int i = 0; i < 8; i++) send_bit(1'b0);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(H / 2);
    chk("ack1_oe_on", {15'd0, sda_oe}, 16'd1);
    @(negedge clk);
    en = 1'b0;
    wclk(1);
    @(negedge clk);
    chk("ack1_oe_off", {15'd0, sda_oe}, 16'd0);
    en = 1'b1;
    wclk(H / 2);
    scl_m = 1'b0; wclk(Q);
    bus_stop();

    for (int t = 0; t < 30; t++) begin
      logic stop_now;
      tx[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      tx[1] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
      tx[2] = 8'($urandom);
      tx[3] = 8'($urandom);
      stop_now = ($urandom_range(0, 4) != 0) || (t == 29);
      xfer($urandom_range(1, 4), stop_now);
      if (stop_now) check_shadow($sformatf("rnd%0d", t));
    end

    wclk(20);
    chk("queue_drained", 16'(q_exp.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
